mano_cycle_ctrl: RTL and testbench
==================================

// Module: mano_cycle_ctrl
// PURPOSE
//   Timing and cycle controller for the basic computer.
//   - Owns the 4-bit sequence counter (SC), the start/stop flip-flop (S) and the interrupt-cycle flip-flop (R).
//   - Drives the one-hot timing bus T, the latched opcode decode D and the indirect bit I.
//   - Every register control block (DR, AR, AC, PC...) builds its LD/CLR/INC terms from these outputs.
// PARAMETERS
//   SC_W     4   sequence counter width; T width is 2**SC_W
//   OPC_W    3   opcode field width; D width is 2**OPC_W
//   IR_W     16  instruction register width; I = ir[IR_W-1], opcode = ir[IR_W-2 -: OPC_W]
// PORTS
//   clk      in   1      system clock, all state changes on rising edge
//   rst_n    in   1      reset, asynchronous assert, active-low
//   start    in   1      1-cycle pulse; sets S when S=0
//   halt     in   1      HLT executed this cycle (D7 & ~I & T3 & IR[0]); clears S
//   sc_clr   in   1      end-of-instruction request from control logic; clears SC
//   ir       in   IR_W   current IR contents (valid from T2)
//   ien      in   1      interrupt-enable flip-flop state
//   fgi      in   1      input flag
//   fgo      in   1      output flag
//   T        out  16     one-hot timing, T[k]=1 iff S=1 and SC=k
//   D        out  8      one-hot opcode decode, registered
//   I        out  1      indirect bit, registered
//   R        out  1      interrupt cycle in progress
//   S        out  1      computer running
//   sc       out  SC_W   raw SC value (debug/visibility)
// BEHAVIOUR
//   Reset (rst_n=0, async):
//   - Clears SC, S, R, I and D; T is 0. Takes effect immediately, mid-instruction included.
//   - The first edge after release is a normal edge.
//   S register:
//   - When S=0, start=1 sets S at the edge and SC stays 0, so the next cycle is T0.
//   - When S=1, halt=1 clears S and SC at the edge.
//   - halt has priority over start; start while S=1 is ignored.
//   SC update when S=1, evaluated at each edge, first match wins:
//   1. halt -> SC=0.
//   2. R=1 and SC==2 (RT2, end of interrupt cycle) -> SC=0 and R=0.
//   3. sc_clr -> SC=0.
//   4. otherwise SC = SC+1, wrapping 15 -> 0 with no flag.
//   - When S=0, SC holds.
//   T output:
//   - T = S ? (1<<SC) : 0, combinational from registers.
//   - Exactly one T bit is high while running; all bits are low while halted.
//   Decode latch:
//   - At the edge ending T2 with R=0, D <= 1<<ir[opcode], I <= ir[IR_W-1].
//   - D and I are therefore valid from T3 until the next T2 edge. Both hold otherwise and during R cycles.
//   Interrupt request:
//   - At an edge with S=1, R=0, SC not in {0,1,2} and ien & (fgi|fgo), R <= 1.
//   - R takes effect from the next T0, because control logic asserts sc_clr at the end of the instruction.
//   - R is not set during T0..T2, so it never interrupts a fetch.
//   - Setting R and sc_clr in the same edge is legal; both apply.
//   Latency:
//   - start to T0 high is 1 cycle.
//   - The opcode in IR at T2 appears on D at T3.
//   Simultaneous events:
//   - halt with sc_clr: SC=0 and S=0.
//   - An R set request in the same edge as halt is dropped.
// TESTING
//   1. Reset, then start pulse -> S=1 next cycle, T=0x0001. 15 further edges with no sc_clr -> T walks to 0x8000, then wraps to 0x0001.
//   2. ir=0x2ABC, run to T2, clock -> D=0x04 and I=0 at T3. ir=0xA000 in the next instruction -> D=0x04, I=1.
//   3. sc_clr asserted during T5 -> next cycle T=0x0001. sc_clr and halt together -> S=0, T=0x0000, start restores T0.
//   4. ien=1, fgi=1 during T4, sc_clr at T4 -> R=1 and T0. Run T0,T1,T2 -> R=0 and SC=0 after T2. D unchanged throughout.
//   5. rst_n pulled low mid-T6 with no clock edge -> T, D, R, S, sc all 0 immediately. They stay 0 after release until start.
//   6. start=1 and halt=1 while S=0 -> S stays 0. halt while S=1 at T3 -> T=0 next cycle.

Source files
------------

// File: rtl/mano_cycle_ctrl.sv
// Timing and cycle controller for the basic computer.
// Owns the sequence counter, the start/stop flag S and the interrupt-cycle
// flag R. It produces the one-hot timing bus T plus the registered opcode
// decode D and the indirect bit I.
module mano_cycle_ctrl #(
    parameter int SC_W  = 4,
    parameter int OPC_W = 3,
    parameter int IR_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  halt,
    input  logic                  sc_clr,
    input  logic [IR_W-1:0]       ir,
    input  logic                  ien,
    input  logic                  fgi,
    input  logic                  fgo,
    output logic [2**SC_W-1:0]    T,
    output logic [2**OPC_W-1:0]   D,
    output logic                  I,
    output logic                  R,
    output logic                  S,
    output logic [SC_W-1:0]       sc
);

    localparam int T_W = 2**SC_W;
    localparam int D_W = 2**OPC_W;
    localparam logic [SC_W-1:0] SC_T2 = SC_W'(2);

    logic [SC_W-1:0] sc_q, sc_d;
    logic            s_q, s_d;
    logic            r_q, r_d;
    logic            i_q, i_d;
    logic [D_W-1:0]  d_q, d_d;

    logic            at_t2;
    logic            fetch_phase;
    logic            irq_req;

    // Next-state for SC, S, R and the decode latch.
    always_comb begin
        sc_d = sc_q;
        s_d  = s_q;
        r_d  = r_q;
        i_d  = i_q;
        d_d  = d_q;

        at_t2       = s_q && (sc_q == SC_T2);
        // SC 0..2 is the fetch/decode window; an interrupt must never cut it.
        fetch_phase = (sc_q <= SC_T2);
        irq_req     = ien && (fgi || fgo);

        if (!s_q) begin
            // halt outranks start; SC is left alone so the first running cycle is T0.
            s_d = start && !halt;
        end else if (halt) begin
            // halt also drops any interrupt request arriving on this edge.
            s_d  = 1'b0;
            sc_d = '0;
        end else begin
            if (r_q && sc_q == SC_T2) begin
                // RT2 closes the interrupt cycle.
                sc_d = '0;
                r_d  = 1'b0;
            end else if (sc_clr) begin
                sc_d = '0;
            end else begin
                sc_d = sc_q + 1'b1;
            end

            // Request is latched mid-execute; it takes hold at the next T0
            // once control logic ends the instruction with sc_clr.
            if (!r_q && !fetch_phase && irq_req)
                r_d = 1'b1;

            // Decode the opcode at the end of T2 of a normal (non-R) cycle.
            if (at_t2 && !r_q) begin
                d_d = '0;
                d_d[ir[IR_W-2 -: OPC_W]] = 1'b1;
                i_d = ir[IR_W-1];
            end
        end
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q <= '0;
            s_q  <= 1'b0;
            r_q  <= 1'b0;
            i_q  <= 1'b0;
            d_q  <= '0;
        end else begin
            sc_q <= sc_d;
            s_q  <= s_d;
            r_q  <= r_d;
            i_q  <= i_d;
            d_q  <= d_d;
        end
    end

    // One-hot timing decode; all low while halted.
    always_comb begin
        T = '0;
        T[sc_q] = s_q;
    end

    assign D  = d_q;
    assign I  = i_q;
    assign R  = r_q;
    assign S  = s_q;
    assign sc = sc_q;

    // T_W is only used to document the bus width relationship.
    logic unused_tw;
    assign unused_tw = (T_W == 0);

endmodule

// File: tb/tb_mano_cycle_ctrl.sv
// Directed bench for mano_cycle_ctrl: timing walk, decode latch,
// sc_clr/halt, interrupt cycle, async reset and halt/start priority.
module tb_mano_cycle_ctrl;

    logic        clk, rst_n, start, halt, sc_clr, ien, fgi, fgo;
    logic [15:0] ir;
    logic [15:0] T;
    logic [7:0]  D;
    logic        I, R, S;
    logic [3:0]  sc;

    int checks   = 0;
    int failures = 0;

    mano_cycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .sc_clr(sc_clr),
        .ir(ir), .ien(ien), .fgi(fgi), .fgo(fgo),
        .T(T), .D(D), .I(I), .R(R), .S(S), .sc(sc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: the directed sequence is short; this only guards a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 0; halt = 0; sc_clr = 0;
        ien = 0; fgi = 0; fgo = 0; ir = 16'h0000;
        #23;
        chk("rst_T", T, 0); chk("rst_S", S, 0); chk("rst_R", R, 0);
        chk("rst_D", D, 0); chk("rst_I", I, 0); chk("rst_sc", sc, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_T", T, 0);

        // 1. start -> T0, walk to T15, wrap to T0
        start = 1; tick(); start = 0;
        chk("start_S", S, 1); chk("start_T", T, 16'h0001);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk($sformatf("walk_T%0d", k), T, 32'(16'h1 << k));
        end
        chk("walk_D", D, 8'h01);
        tick();
        chk("wrap_T", T, 16'h0001);

        // 2. decode latch
        ir = 16'h2ABC;
        ticks(3);
        chk("dec1_T", T, 16'h0008); chk("dec1_D", D, 8'h04); chk("dec1_I", I, 0);
        sc_clr = 1; tick(); sc_clr = 0;
        chk("clr_T3", T, 16'h0001);
        ir = 16'hA000;
        ticks(3);
        chk("dec2_D", D, 8'h04); chk("dec2_I", I, 1);

        // 3. sc_clr at T5, then sc_clr+halt, then restart
        ticks(2);
        chk("t5_T", T, 16'h0020);
        sc_clr = 1; tick(); sc_clr = 0;
        chk("clr_T5", T, 16'h0001);
        tick();
        sc_clr = 1; halt = 1; tick(); sc_clr = 0; halt = 0;
        chk("hclr_S", S, 0); chk("hclr_T", T, 0); chk("hclr_sc", sc, 0);
        tick();
        chk("halted_T", T, 0);
        start = 1; tick(); start = 0;
        chk("restart_T", T, 16'h0001);

        // 4. interrupt cycle
        ticks(4);
        chk("irq_T4", T, 16'h0010);
        ien = 1; fgi = 1; sc_clr = 1; tick(); ien = 0; fgi = 0; sc_clr = 0;
        chk("irq_R", R, 1); chk("irq_T", T, 16'h0001);
        ir = 16'h7000;
        tick(); chk("rt1_R", R, 1);
        tick(); chk("rt2_R", R, 1); chk("rt2_T", T, 16'h0004);
        tick();
        chk("rend_R", R, 0); chk("rend_sc", sc, 0);
        chk("rend_D", D, 8'h04); chk("rend_I", I, 1);
        // request held through fetch must not set R until T3
        ien = 1; fgo = 1;
        ticks(2); chk("fetch_R", R, 0);
        tick();
        chk("fetch3_R", R, 0); chk("dec3_D", D, 8'h80); chk("dec3_I", I, 0);
        tick(); ien = 0; fgo = 0;
        chk("t3irq_R", R, 1); chk("t3irq_T", T, 16'h0010);
        sc_clr = 1; tick(); sc_clr = 0;
        ticks(3);
        chk("rend2_R", R, 0); chk("rend2_T", T, 16'h0001);

        // 5. async reset mid-T6
        ticks(6);
        chk("t6_T", T, 16'h0040);
        #2 rst_n = 0; #1;
        chk("arst_T", T, 0); chk("arst_D", D, 0); chk("arst_R", R, 0);
        chk("arst_S", S, 0); chk("arst_sc", sc, 0); chk("arst_I", I, 0);
        #1 rst_n = 1;
        ticks(2);
        chk("post_T", T, 0); chk("post_S", S, 0);
        start = 1; tick(); start = 0;
        chk("post_start_T", T, 16'h0001);

        // 6. halt at T3 (with a dropped R request), then start+halt while stopped
        ticks(3);
        chk("h_T3", T, 16'h0008);
        halt = 1; ien = 1; fgi = 1; tick(); halt = 0; ien = 0; fgi = 0;
        chk("halt_T", T, 0); chk("halt_S", S, 0); chk("halt_R", R, 0);
        start = 1; halt = 1; tick(); start = 0; halt = 0;
        chk("sh_S", S, 0); chk("sh_T", T, 0);
        tick();
        chk("sh2_S", S, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
